keypad_scan_ctrl: RTL and testbench

//  Parametrised matrix-keypad scanner, successor to enterDigit. Drives one row at a

---
 rtl/keypad_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Purpose : matrix-keypad scanner; drives one row at a time, debounces whole-matrix
//           frames and emits one event per clean single-key press.
// Latency : key_valid rises on the frame-complete sample that makes a pattern stable
//           (DEBOUNCE+1 identical frames after bouncing stops).
// Backpr. : one-entry event register; an event arriving while the previous one is
//           still pending and not being accepted is dropped and sets sticky overrun.
//
// Ports:
//   hwclk, rst_n      clock, async active-low reset
//   row_o[ROWS]       one-hot active-high row drive
//   col_i[COLS]       asynchronous column sense (active-high)
//   key_code/valid/ready  event handshake; key_code = row*COLS + col
//   key_held          FSM is in HELD (exactly one debounced key down)
//   multi_key         FSM is in MULTI (two or more debounced keys down)
//   overrun/clr_overrun   sticky dropped-event flag and its clear
module keypad_scan_ctrl #(
    parameter int ROWS     = 3,
    parameter int COLS     = 3,
    parameter int SCAN_DIV = 12000,
    parameter int DEBOUNCE = 20,
    parameter int CODE_W   = 4
) (
    input  logic              hwclk,
    input  logic              rst_n,
    output logic [ROWS-1:0]   row_o,
    input  logic [COLS-1:0]   col_i,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              multi_key,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int NKEYS = ROWS * COLS;
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW    = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_MULTI = 2'd2
    } state_t;

    // column synchroniser
    logic [COLS-1:0]  col_meta;
    logic [COLS-1:0]  col_sync;

    // scan state
    logic [DW-1:0]    dwell;
    logic [RW-1:0]    row_idx;
    logic [NKEYS-1:0] frame;
    logic [NKEYS-1:0] frame_next;
    logic             last_dwell;
    logic             frame_done;

    // debounce state; prev doubles as the debounced pattern once stable_cnt
    // has reached DEBOUNCE, so no separate copy is kept
    logic [NKEYS-1:0] prev;
    logic [SW-1:0]    stable_cnt;
    logic             same_frame;
    logic             deb_upd;

    // decode of the pattern being accepted
    logic             pat_any;
    logic             pat_many;
    logic [CODE_W-1:0] pat_code;

    state_t           state;
    state_t           state_nxt;
    logic             issue;
    logic             drop;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= col_i;
            col_sync <= col_meta;
        end
    end

    assign row_o = ROWS'(1) << row_idx;

    always_comb begin
        last_dwell = (dwell == DW'(SCAN_DIV - 1));
        frame_done = last_dwell && (row_idx == RW'(ROWS - 1));
        // frame as it will look once the current row is sampled; the completing
        // row is folded in here so debounce sees the whole frame on the same edge
        frame_next = frame;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx == RW'(r)) begin
                frame_next[r*COLS +: COLS] = col_sync;
            end
        end
        same_frame = (frame_next == prev);
        // fires only on the transition into DEBOUNCE, so a pattern that stays
        // stable is evaluated exactly once
        deb_upd = frame_done && same_frame && (stable_cnt == SW'(DEBOUNCE - 1));
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            dwell      <= '0;
            row_idx    <= '0;
            frame      <= '0;
            prev       <= '0;
            stable_cnt <= '0;
        end else begin
            if (last_dwell) begin
                dwell <= '0;
                frame <= frame_next;
                if (row_idx == RW'(ROWS - 1)) begin
                    row_idx <= '0;
                end else begin
                    row_idx <= row_idx + RW'(1);
                end
            end else begin
                dwell <= dwell + DW'(1);
            end

            if (frame_done) begin
                prev <= frame_next;
                if (!same_frame) begin
                    stable_cnt <= '0;
                end else if (stable_cnt != SW'(DEBOUNCE)) begin
                    stable_cnt <= stable_cnt + SW'(1);
                end
            end
        end
    end

    // key-count classification and code of the lowest pressed key
    always_comb begin
        pat_any  = 1'b0;
        pat_many = 1'b0;
        pat_code = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (frame_next[i]) begin
                if (pat_any) begin
                    pat_many = 1'b1;
                end
                pat_any = 1'b1;
                if (!pat_many) begin
                    pat_code = CODE_W'(i);
                end
            end
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (deb_upd) begin
            case (state)
                ST_IDLE: begin
                    if (pat_many) begin
                        state_nxt = ST_MULTI;
                    end else if (pat_any) begin
                        state_nxt = ST_HELD;
                        issue     = 1'b1;
                    end
                end
                ST_HELD: begin
                    // any change away from the held key is treated as a chord;
                    // a fresh press always needs a return through IDLE
                    state_nxt = pat_any ? ST_MULTI : ST_IDLE;
                end
                ST_MULTI: begin
                    if (!pat_any) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        drop = issue && key_valid && !key_ready;
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_held  <= (state_nxt == ST_HELD);
            multi_key <= (state_nxt == ST_MULTI);
        end
    end

    // event register: a new event may load on the same edge the old one is
    // accepted, keeping key_valid high without a bubble
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (issue && !drop) begin
                key_code  <= pat_code;
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int SDIV  = 4;
    localparam int DEB   = 2;
    localparam int CW    = 4;
    localparam int FRAME = ROWS * SDIV;

    logic            hwclk = 1'b0;
    logic            rst_n;
    logic [ROWS-1:0] row_o;
    logic [COLS-1:0] col_i;
    logic [CW-1:0]   key_code;
    logic            key_valid;
    logic            key_ready;
    logic            key_held;
    logic            multi_key;
    logic            overrun;
    logic            clr_overrun;

    logic [ROWS*COLS-1:0] pressed;

    int errors = 0;
    int checks = 0;

    // reference model state
    localparam int M_IDLE  = 0;
    localparam int M_HELD  = 1;
    localparam int M_MULTI = 2;
    logic [ROWS*COLS-1:0] m_prev;
    int m_run;
    int m_state;
    bit m_pending;
    bit m_ovr;
    int m_code;
    int exp_q[$];

    always #5 hwclk = ~hwclk;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB), .CODE_W(CW)
    ) dut (
        .hwclk(hwclk), .rst_n(rst_n), .row_o(row_o), .col_i(col_i),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .multi_key(multi_key), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    // physical keypad: a pressed key connects its row line to its column line
    always_comb begin
        col_i = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row_o[r] && pressed[r*COLS + c]) col_i[c] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev    = '0;
        m_run     = 1;
        m_state   = M_IDLE;
        m_pending = 1'b0;
        m_ovr     = 1'b0;
        m_code    = 0;
        exp_q.delete();
    endtask

    // mode 0: ready low all frame; 1: ready high all frame;
    // 2: ready low, raised for the final cycle of the frame only
    task automatic model_frame(input logic [ROWS*COLS-1:0] pat, input int mode, input bit clr);
        bit ev = 1'b0;
        int n  = $countones(pat);
        int code = 0;
        for (int i = 0; i < ROWS*COLS; i++) if (pat[i]) code = i;
        if (pat == m_prev) m_run++;
        else begin
            m_prev = pat;
            m_run  = 1;
        end
        if (m_run == DEB + 1) begin
            if (m_state == M_IDLE) begin
                if (n == 1) begin
                    m_state = M_HELD;
                    ev = 1'b1;
                end else if (n >= 2) m_state = M_MULTI;
            end else if (m_state == M_HELD) begin
                m_state = (n == 0) ? M_IDLE : M_MULTI;
            end else if (n == 0) begin
                m_state = M_IDLE;
            end
        end
        if (clr) m_ovr = 1'b0;
        if (ev) begin
            if (mode == 0 && m_pending) m_ovr = 1'b1;
            else begin
                exp_q.push_back(code);
                m_code = code;
            end
        end
        m_pending = (mode == 0) ? (m_pending | ev) : ev;
    endtask

    // called #1 after a frame boundary edge; returns #1 after the next one
    task automatic do_frame(input logic [ROWS*COLS-1:0] pat, input int mode, input bit clr);
        pressed   = pat;
        key_ready = (mode == 1);
        model_frame(pat, mode, clr);
        for (int c = 0; c < FRAME; c++) begin
            @(posedge hwclk);
            #1;
            if (c == 4 && clr) clr_overrun = 1'b1;
            if (c == 5) clr_overrun = 1'b0;
            if (c == FRAME - 2 && mode == 2) key_ready = 1'b1;
        end
        chk("key_held",  int'(key_held),  (m_state == M_HELD)  ? 1 : 0);
        chk("multi_key", int'(multi_key), (m_state == M_MULTI) ? 1 : 0);
        chk("key_valid", int'(key_valid), int'(m_pending));
        chk("overrun",   int'(overrun),   int'(m_ovr));
        if (m_pending) chk("pending_code", int'(key_code), m_code);
    endtask

    task automatic repeat_frame(input logic [ROWS*COLS-1:0] pat, input int n, input int mode);
        for (int i = 0; i < n; i++) do_frame(pat, mode, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_row_o"},     int'(row_o),     1);
        chk({tag, "_key_valid"}, int'(key_valid), 0);
        chk({tag, "_key_code"},  int'(key_code),  0);
        chk({tag, "_key_held"},  int'(key_held),  0);
        chk({tag, "_multi_key"}, int'(multi_key), 0);
        chk({tag, "_overrun"},   int'(overrun),   0);
    endtask

    // scoreboard consumer: every accepted handshake must match the oldest expected code
    task automatic monitor();
        forever begin
            @(negedge hwclk);
            if (rst_n && key_valid && key_ready) begin
                if (exp_q.size() == 0) chk("unexpected_event", int'(key_code), -1);
                else chk("event_code", int'(key_code), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        logic [ROWS*COLS-1:0] pat;
        int kind, a, b, hold, mode;
        bit clr;

        rst_n       = 1'b0;
        key_ready   = 1'b0;
        clr_overrun = 1'b0;
        pressed     = '0;
        model_reset();
        fork
            monitor();
        join_none
        repeat (3) @(posedge hwclk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        // single key (1,2): event with ready low, then accept, then release
        repeat_frame(9'h020, 3, 0);
        repeat_frame(9'h020, 1, 1);
        repeat_frame(9'h000, 3, 1);

        // bouncing key (0,1) then steady
        for (int i = 0; i < 5; i++) do_frame((i % 2 == 0) ? 9'h002 : 9'h000, 1, 1'b0);
        repeat_frame(9'h002, 3, 1);
        repeat_frame(9'h000, 3, 1);

        // chord (0,0)+(2,1), partial release, full release
        repeat_frame(9'h081, 3, 1);
        repeat_frame(9'h001, 3, 1);
        repeat_frame(9'h000, 3, 1);

        // overrun: key 4 pending, key 8 dropped, clear, then accept
        repeat_frame(9'h010, 3, 0);
        repeat_frame(9'h000, 3, 0);
        repeat_frame(9'h100, 3, 0);
        do_frame(9'h000, 0, 1'b1);
        repeat_frame(9'h000, 2, 0);
        repeat_frame(9'h000, 1, 1);

        // new event lands on the accept edge of the previous one
        repeat_frame(9'h004, 3, 0);
        repeat_frame(9'h000, 3, 0);
        repeat_frame(9'h040, 2, 0);
        do_frame(9'h040, 2, 1'b0);
        repeat_frame(9'h000, 3, 1);

        // randomized patterns, hold times, backpressure and clears
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom_range(0, 8);
            b    = (a + $urandom_range(1, 8)) % 9;
            pat  = '0;
            if (kind == 1) pat[a] = 1'b1;
            else if (kind == 2) begin
                pat[a] = 1'b1;
                pat[b] = 1'b1;
            end else if (kind == 3) pat = 9'($urandom_range(0, 511));
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
                clr  = ($urandom_range(0, 3) == 0);
                do_frame(pat, mode, clr);
            end
        end
        repeat_frame(9'h000, 4, 1);

        // build pending + overrun state, then reset in the middle of a frame
        repeat_frame(9'h008, 3, 0);
        repeat_frame(9'h000, 3, 0);
        repeat_frame(9'h080, 3, 0);
        chk("pre_reset_overrun", int'(overrun), 1);
        repeat (5) @(posedge hwclk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        pressed = '0;
        @(posedge hwclk);
        #1;
        rst_n = 1'b1;
        repeat_frame(9'h000, 4, 1);

        chk("leftover_events", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
